muldiv_sequencer: RTL and testbench

Multicycle controller and iterative datapath for the signed MULT and DIV instructions of the MIPS processor. The control unit launches an operation with a one-cycle start pulse and waits while busy is high. On completion the block loads HI/LO, pulses done, or pulses div0 so the control unit can enter its exception path. HI/LO are held here and read by the mfhi/mflo paths.

---
 rtl/muldiv_sequencer.sv | 177 +++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Signed MULT/DIV sequencer for the MIPS core.
// Iterative shift-add multiply and restoring divide, HI/LO held here.
module muldiv_sequencer #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clock,
    input  logic              RESET_in,
    input  logic              start_mult,
    input  logic              start_div,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    output logic              busy,
    output logic              done,
    output logic              div0,
    output logic [DATA_W-1:0] HI,
    output logic [DATA_W-1:0] LO
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MULT,
        S_DIV,
        S_FIX,
        S_DONE,
        S_DZ
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    // upper half: partial product / remainder
    // lower half: multiplier / quotient
    logic [2*DATA_W-1:0] acc_q;
    // multiplicand or divisor magnitude
    logic [DATA_W-1:0]   opnd_q;
    logic                is_div_q;
    logic                neg_lo_q;
    logic                neg_hi_q;
    logic                busy_q;
    logic                done_q;
    logic                div0_q;
    logic [DATA_W-1:0]   hi_q;
    logic [DATA_W-1:0]   lo_q;

    logic [DATA_W-1:0]   abs_a;
    logic [DATA_W-1:0]   abs_b;
    logic [DATA_W:0]     mul_sum;
    logic [2*DATA_W-1:0] mul_d;
    logic [DATA_W:0]     rem_sh;
    logic                rem_ge;
    logic [DATA_W-1:0]   rem_sub;
    logic [2*DATA_W-1:0] div_d;
    logic [2*DATA_W-1:0] prod_fix;
    logic [DATA_W-1:0]   quo_fix;
    logic [DATA_W-1:0]   rem_fix;

    // Operand magnitudes, one iteration step of each op, and sign fix-up.
    always_comb begin
        abs_a = A[DATA_W-1] ? -A : A;
        abs_b = B[DATA_W-1] ? -B : B;

        mul_sum = {1'b0, acc_q[2*DATA_W-1:DATA_W]}
                + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_d   = {mul_sum, acc_q[DATA_W-1:1]};

        // The subtract result always fits DATA_W bits when it is kept.
        rem_sh  = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
        rem_ge  = rem_sh >= {1'b0, opnd_q};
        rem_sub = rem_sh[DATA_W-1:0] - opnd_q;
        if (rem_ge) begin
            div_d = {rem_sub, acc_q[DATA_W-2:0], 1'b1};
        end else begin
            div_d = {rem_sh[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0};
        end

        prod_fix = neg_lo_q ? -acc_q : acc_q;
        quo_fix  = neg_lo_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
        rem_fix  = neg_hi_q ? -acc_q[2*DATA_W-1:DATA_W]
                            : acc_q[2*DATA_W-1:DATA_W];
    end

    // Control FSM with datapath registers and registered status outputs.
    always_ff @(posedge clock or posedge RESET_in) begin
        if (RESET_in) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            div0_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            done_q <= 1'b0;
            div0_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_mult) begin
                        state_q  <= S_MULT;
                        cnt_q    <= '0;
                        acc_q    <= {{DATA_W{1'b0}}, abs_b};
                        opnd_q   <= abs_a;
                        is_div_q <= 1'b0;
                        neg_lo_q <= A[DATA_W-1] ^ B[DATA_W-1];
                        neg_hi_q <= A[DATA_W-1] ^ B[DATA_W-1];
                        busy_q   <= 1'b1;
                    end else if (start_div) begin
                        if (B != '0) begin
                            state_q  <= S_DIV;
                            cnt_q    <= '0;
                            acc_q    <= {{DATA_W{1'b0}}, abs_a};
                            opnd_q   <= abs_b;
                            is_div_q <= 1'b1;
                            neg_lo_q <= A[DATA_W-1] ^ B[DATA_W-1];
                            neg_hi_q <= A[DATA_W-1];
                            busy_q   <= 1'b1;
                        end else begin
                            state_q <= S_DZ;
                        end
                    end
                end
                S_MULT: begin
                    acc_q <= mul_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST) begin
                        state_q <= S_FIX;
                    end
                end
                S_DIV: begin
                    acc_q <= div_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (is_div_q) begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end else begin
                        hi_q <= prod_fix[2*DATA_W-1:DATA_W];
                        lo_q <= prod_fix[DATA_W-1:0];
                    end
                    cnt_q   <= '0;
                    state_q <= S_DONE;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                // div0 is raised on the way out of DZ, HI/LO untouched
                S_DZ: begin
                    state_q <= S_IDLE;
                    div0_q  <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign div0 = div0_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer.
// Hand-computed HI/LO, latency, busy and pulse checks.
module tb_muldiv_sequencer;

    logic        clock = 1'b0;
    logic        RESET_in;
    logic        start_mult;
    logic        start_div;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic        div0;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_cmp = 0;
    int n_bad = 0;
    int lat;
    int nb;

    muldiv_sequencer #(.DATA_W(32), .CNT_W(6)) dut (
        .clock      (clock),
        .RESET_in   (RESET_in),
        .start_mult (start_mult),
        .start_div  (start_div),
        .A          (A),
        .B          (B),
        .busy       (busy),
        .done       (done),
        .div0       (div0),
        .HI         (HI),
        .LO         (LO)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Launch one op; lat = edge number where done/div0 first seen,
    // nb = number of sampled cycles with busy high.
    task automatic op(input logic m, input logic d,
                      input logic [31:0] a, input logic [31:0] b,
                      input int disturb_at,
                      output int lt, output int nbz);
        @(negedge clock);
        while (done) @(negedge clock);
        start_mult = m;
        start_div  = d;
        A = a;
        B = b;
        @(posedge clock);
        #1;
        start_mult = 1'b0;
        start_div  = 1'b0;
        nbz = busy ? 1 : 0;
        lt  = -1;
        for (int i = 1; i <= 60; i++) begin
            if (i == disturb_at) begin
                start_div = 1'b1;
                A = 32'h0000_0001;
                B = 32'h0000_0000;
            end
            if (i == disturb_at + 1) start_div = 1'b0;
            @(posedge clock);
            #1;
            if (busy) nbz++;
            if (done || div0) begin
                lt = i;
                break;
            end
        end
    endtask

    initial begin
        RESET_in   = 1'b1;
        start_mult = 1'b0;
        start_div  = 1'b0;
        A = '0;
        B = '0;
        #12;
        check("rst_hi", HI, 0);
        check("rst_lo", LO, 0);
        check("rst_flags", {busy, done, div0}, 0);
        @(negedge clock);
        RESET_in = 1'b0;

        // 7 * -3 = -21
        op(1, 0, 32'd7, 32'hFFFF_FFFD, 0, lat, nb);
        check("mul_lat", lat, 33);
        check("mul_busy_cycles", nb, 33);
        check("mul_hi", HI, 32'hFFFF_FFFF);
        check("mul_lo", LO, 32'hFFFF_FFEB);
        // start raised during DONE must be dropped
        @(negedge clock);
        start_mult = 1'b1;
        A = 32'd2;
        B = 32'd2;
        @(posedge clock);
        #1;
        start_mult = 1'b0;
        check("done_pulse_width", done, 0);
        check("b2b_ignored_busy", busy, 0);
        @(posedge clock);
        #1;
        check("b2b_ignored_idle", busy, 0);
        check("b2b_hi_kept", HI, 32'hFFFF_FFFF);
        check("b2b_lo_kept", LO, 32'hFFFF_FFEB);

        // min * min = 2^62
        op(1, 0, 32'h8000_0000, 32'h8000_0000, 0, lat, nb);
        check("mulmin_hi", HI, 32'h4000_0000);
        check("mulmin_lo", LO, 32'h0000_0000);

        // -7 / 2 = -3 rem -1
        op(0, 1, 32'hFFFF_FFF9, 32'd2, 0, lat, nb);
        check("div_lat", lat, 33);
        check("div_busy_cycles", nb, 33);
        check("div_lo", LO, 32'hFFFF_FFFD);
        check("div_hi", HI, 32'hFFFF_FFFF);

        // 100 / -7 = -14 rem 2
        op(0, 1, 32'd100, 32'hFFFF_FFF9, 0, lat, nb);
        check("div2_lo", LO, 32'hFFFF_FFF2);
        check("div2_hi", HI, 32'd2);

        // min / -1 wraps
        op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat, nb);
        check("divovf_lo", LO, 32'h8000_0000);
        check("divovf_hi", HI, 32'h0);
        check("divovf_div0", div0, 0);

        // preload -1 * 5 = -5, then divide by zero
        op(1, 0, 32'hFFFF_FFFF, 32'd5, 0, lat, nb);
        check("pre_lo", LO, 32'hFFFF_FFFB);
        op(0, 1, 32'd9, 32'd0, 0, lat, nb);
        check("dz_lat", lat, 1);
        check("dz_busy_cycles", nb, 0);
        check("dz_done", done, 0);
        check("dz_hi", HI, 32'hFFFF_FFFF);
        check("dz_lo", LO, 32'hFFFF_FFFB);
        @(posedge clock);
        #1;
        check("dz_pulse_width", div0, 0);

        // async reset in the middle of a multiply
        @(negedge clock);
        start_mult = 1'b1;
        A = 32'h0123_4567;
        B = 32'h0000_0089;
        @(posedge clock);
        #1;
        start_mult = 1'b0;
        repeat (10) @(posedge clock);
        #3;
        check("pre_rst_busy", busy, 1);
        RESET_in = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_hi", HI, 0);
        check("midrst_lo", LO, 0);
        @(negedge clock);
        RESET_in = 1'b0;
        op(1, 0, 32'd5, 32'd6, 0, lat, nb);
        check("postrst_lat", lat, 33);
        check("postrst_lo", LO, 32'd30);
        check("postrst_hi", HI, 32'd0);

        // both starts: multiply wins (3*4, not 3/4)
        op(1, 1, 32'd3, 32'd4, 0, lat, nb);
        check("both_lat", lat, 33);
        check("both_lo", LO, 32'd12);
        check("both_hi", HI, 32'd0);

        // -100 * 9 with start_div and operand changes mid-op
        op(1, 0, 32'hFFFF_FF9C, 32'd9, 5, lat, nb);
        check("dist_lat", lat, 33);
        check("dist_lo", LO, 32'hFFFF_FC7C);
        check("dist_hi", HI, 32'hFFFF_FFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
